// File: rtl/gpr_wr_sched.sv
// Write-port scheduler: captures up to three register writes per instruction and
// drains them through the single register-file write port in the order ovf, link, main.
module gpr_wr_sched #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned LINK_REG = 31,
    parameter int unsigned OVF_REG  = 30,
    parameter int unsigned OVF_VAL  = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWr,
    input  logic [AW-1:0]    rw,
    input  logic [DW-1:0]    busW,
    input  logic             jal_sel,
    input  logic [DW-1:0]    jalsw,
    input  logic             over,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [DW-1:0]    wr_data,
    output logic             busy,
    output logic [CNT_W-1:0] wr_cnt
);

    localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);
    localparam logic [AW-1:0] OVF_A  = AW'(OVF_REG);
    localparam logic [DW-1:0] OVF_D  = DW'(OVF_VAL);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    // Entry slots: 0 = overflow flag, 1 = link, 2 = main (also the issue order)
    state_t           state_q, state_d;
    logic [2:0]       pend_q, pend_d;
    ent_t [2:0]       ent_q, ent_d;
    logic             wr_en_d;
    logic [AW-1:0]    wr_addr_d;
    logic [DW-1:0]    wr_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]       cand_v;
    logic [2:0]       rem_v;
    ent_t [2:0]       cand_e;
    ent_t             iss;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            ent_q   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ent_q   <= ent_d;
            wr_en   <= wr_en_d;
            wr_addr <= wr_addr_d;
            wr_data <= wr_data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture in IDLE or continue draining, then issue the first pending entry
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        ent_d     = ent_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        cnt_d     = cnt_q;
        cand_v    = pend_q;
        cand_e    = ent_q;
        iss       = '0;
        rem_v     = '0;

        if (state_q == IDLE) begin
            cand_e[0].addr = OVF_A;
            cand_e[0].data = OVF_D;
            cand_e[1].addr = LINK_A;
            cand_e[1].data = jalsw;
            cand_e[2].addr = rw;
            cand_e[2].data = busW;
            // Entries targeting $0 are dropped here and never issue
            if (RegWr) begin
                cand_v = {(rw != '0), (jal_sel && (LINK_A != '0)), (over && (OVF_A != '0))};
            end else begin
                cand_v = 3'b000;
            end
            ent_d = cand_e;
        end

        if (cand_v[0]) begin
            iss   = cand_e[0];
            rem_v = cand_v & 3'b110;
        end else if (cand_v[1]) begin
            iss   = cand_e[1];
            rem_v = cand_v & 3'b100;
        end else begin
            iss   = cand_e[2];
            rem_v = 3'b000;
        end

        if (cand_v != 3'b000) begin
            wr_en_d   = 1'b1;
            wr_addr_d = iss.addr;
            wr_data_d = iss.data;
            pend_d    = rem_v;
            state_d   = (rem_v != 3'b000) ? DRAIN : IDLE;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            pend_d  = 3'b000;
            state_d = IDLE;
        end
    end

    assign busy   = (state_q == DRAIN);
    assign wr_cnt = cnt_q;

endmodule
